// File: rtl/alu_shift_sequencer.sv
// Iterative SLL/SRL/SRA unit for an ALU without a barrel shifter.
// Shifts STEP bits per cycle, stalls the front end, and pulses done with a registered result.
module alu_shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    shamt,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    localparam logic [SW:0] STEP_AMT = (SW+1)'(STEP);

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [1:0]       op_reg, op_next;
    logic [SW:0]      rem_reg, rem_next;
    logic             sign_reg, sign_next;

    logic [SW:0]      shift_amt;
    logic [SW:0]      rem_left;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;

    // The last step may be partial when rem is not a multiple of STEP.
    assign shift_amt = (rem_reg < STEP_AMT) ? rem_reg : STEP_AMT;
    assign rem_left  = rem_reg - shift_amt;

    // Bit gi is vacated by a right shift of shift_amt when gi + shift_amt >= WIDTH.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fill
            assign fill_mask[gi] = ({1'b0, shift_amt} + (SW+2)'(gi)) >= (SW+2)'(WIDTH);
        end
    endgenerate

    always_comb begin
        shifted = result_reg;
        case (op_reg)
            OP_SLL:  shifted = result_reg << shift_amt;
            OP_SRL:  shifted = result_reg >> shift_amt;
            OP_SRA:  shifted = (result_reg >> shift_amt) | (sign_reg ? fill_mask : '0);
            default: shifted = result_reg;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        op_next     = op_reg;
        rem_next    = rem_reg;
        sign_next   = sign_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && !flush) begin
                    result_next = a;
                    op_next     = op;
                    rem_next    = {1'b0, shamt};
                    sign_next   = a[WIDTH-1];
                    state_next  = (shamt == '0 || op == 2'b11) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    result_next = shifted;
                    rem_next    = rem_left;
                    if (rem_left == '0) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            op_reg     <= OP_SLL;
            rem_reg    <= '0;
            sign_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            op_reg     <= op_next;
            rem_reg    <= rem_next;
            sign_reg   <= sign_next;
        end
    end

    // Low in DONE so the pipeline advances and captures result; low during flush and reset.
    assign stall  = !rst && !flush &&
                    (((state_reg == ST_IDLE) && start) || (state_reg == ST_SHIFT));
    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Scoreboard bench for alu_shift_sequencer: STEP=1 and STEP=4 instances, directed vectors.
module tb_alu_shift_sequencer;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic        start4 = 1'b0;
    logic        flush  = 1'b0;
    logic [1:0]  op     = 2'b00;
    logic [31:0] a      = 32'h0;
    logic [4:0]  shamt  = 5'd0;

    logic        stall, busy, done;
    logic [31:0] result;
    logic        stall4, busy4, done4;
    logic [31:0] result4;

    typedef struct {
        logic [31:0] res;
        int          sc;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    alu_shift_sequencer #(.WIDTH(32), .STEP(1), .SW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .shamt(shamt), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    alu_shift_sequencer #(.WIDTH(32), .STEP(4), .SW(5)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .a(a), .shamt(shamt), .flush(flush),
        .stall(stall4), .busy(busy4), .done(done4), .result(result4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: pops an expectation whenever either instance pulses done.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done step1: got result %h, expected no done", result);
            end else begin
                e = q1.pop_front();
                chk("step1_result", result, e.res);
                chk("step1_latency", cyc - e.sc, e.lat);
                $display("txn step1 result=%h expected=%h latency=%0d", result, e.res, cyc - e.sc);
            end
        end
        if (done4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done step4: got result %h, expected no done", result4);
            end else begin
                e = q4.pop_front();
                chk("step4_result", result4, e.res);
                chk("step4_latency", cyc - e.sc, e.lat);
                $display("txn step4 result=%h expected=%h latency=%0d", result4, e.res, cyc - e.sc);
            end
        end
    end

    // Issue one op (called just after a rising edge) and count stall cycles until done.
    task automatic run_op(input bit u4, input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] sh, input logic [31:0] expv, input int lat,
                          input string nm);
        exp_t e;
        int   st_cnt;
        bit   seen;
        op     = o;
        a      = av;
        shamt  = sh;
        e.res  = expv;
        e.sc   = cyc;
        e.lat  = lat;
        if (u4) begin
            q4.push_back(e);
            start4 = 1'b1;
        end else begin
            q1.push_back(e);
            start = 1'b1;
        end
        st_cnt = 0;
        seen   = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (u4 ? stall4 : stall) st_cnt++;
            if (u4 ? done4 : done) seen = 1'b1;
            @(posedge clk);
            #1;
            start  = 1'b0;
            start4 = 1'b0;
            a      = $urandom;
            op     = 2'($urandom_range(3));
            shamt  = 5'($urandom_range(31));
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in 100 cycles, expected done at +%0d", nm, lat);
        end
        chk({nm, "_stall_cycles"}, st_cnt, lat);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        shamt = 5'd5;
        #12;
        chk("reset_stall", stall, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 32'h0);
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, "sll31");
        run_op(0, 2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000, 5,  "sra4");
        run_op(0, 2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000, 5,  "srl4");
        run_op(0, 2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000, 5,  "sra_pos");
        run_op(0, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  "shamt0");
        run_op(0, 2'b11, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1,  "op11");
        run_op(1, 2'b01, 32'h8000_0000, 5'd7,  32'h0100_0000, 3,  "s4_srl7");
        run_op(1, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9,  "s4_sll31");
        run_op(1, 2'b10, 32'h8000_0000, 5'd9,  32'hFFC0_0000, 4,  "s4_sra9");

        // Flush in the third SHIFT cycle of a shamt=10 op: no done may follow.
        op    = 2'b00;
        a     = 32'h0000_0001;
        shamt = 5'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", stall, 0);
        chk("flush_busy_before", busy, 1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_after", busy, 0);
        @(posedge clk);
        #1;
        run_op(0, 2'b01, 32'h8000_0000, 5'd10, 32'h0020_0000, 11, "after_flush");

        // start held through DONE must not be accepted.
        op    = 2'b00;
        a     = 32'h1234_5678;
        shamt = 5'd0;
        e.res = 32'h1234_5678;
        e.sc  = cyc;
        e.lat = 1;
        q1.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("done_state_busy", busy, 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_in_done_ignored", busy, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset between edges while shifting.
        op    = 2'b00;
        a     = 32'h0000_0003;
        shamt = 5'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        start = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 32'h0);
        chk("rst_stall", stall, 0);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", q1.size() + q4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
